// File: rtl/vend_pkg.sv
// Purpose : shared types and constants for the vending controller slice.
// Contents: FSM state enum, drink codes, coin denominations, default prices.
// Users   : vend_controller, change_maker (import vend_pkg::*).
package vend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACCUM    = 2'd1,
    ST_DISPENSE = 2'd2,
    ST_CHANGE   = 2'd3
  } state_t;

  localparam logic [2:0] DRINK_NONE   = 3'b000;
  localparam logic [2:0] DRINK_TEA    = 3'b001;
  localparam logic [2:0] DRINK_COKE   = 3'b010;
  localparam logic [2:0] DRINK_COFFEE = 3'b011;
  localparam logic [2:0] DRINK_MILK   = 3'b100;

  localparam logic [5:0] COIN_1  = 6'd1;
  localparam logic [5:0] COIN_5  = 6'd5;
  localparam logic [5:0] COIN_10 = 6'd10;

  localparam int DEF_PRICE_TEA    = 10;
  localparam int DEF_PRICE_COKE   = 15;
  localparam int DEF_PRICE_COFFEE = 20;
  localparam int DEF_PRICE_MILK   = 25;

endpackage

// File: rtl/vend_controller_change_maker.sv
// Purpose : greedy change selection -- largest of {10,5,1} not above the credit.
// Ports   : i_credit (remaining credit), o_coin (0 when credit is 0).
// Timing  : purely combinational, no backpressure.
module change_maker
  import vend_pkg::*;
(
  input  logic [5:0] i_credit,
  output logic [5:0] o_coin
);

  always_comb begin
    o_coin = '0;
    if (i_credit >= COIN_10)     o_coin = COIN_10;
    else if (i_credit >= COIN_5) o_coin = COIN_5;
    else if (i_credit >= COIN_1) o_coin = COIN_1;
  end

endmodule

// File: rtl/vend_controller.sv
// Purpose : vending machine controller -- coin credit, drink dispense, greedy change.
// Ports   : coin/coin_valid/drink_choose/cancel in; give/give_valid to dispenser
//           (held until disp_ready), refund_coin/refund_valid to hopper (held until
//           refund_ready); total_coin, coin_reject, busy status. All outputs registered.
module vend_controller
  import vend_pkg::*;
#(
  parameter int PRICE_TEA    = DEF_PRICE_TEA,
  parameter int PRICE_COKE   = DEF_PRICE_COKE,
  parameter int PRICE_COFFEE = DEF_PRICE_COFFEE,
  parameter int PRICE_MILK   = DEF_PRICE_MILK
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] coin,
  input  logic       coin_valid,
  input  logic [2:0] drink_choose,
  input  logic       cancel,
  input  logic       disp_ready,
  input  logic       refund_ready,
  output logic [2:0] give,
  output logic       give_valid,
  output logic [5:0] refund_coin,
  output logic       refund_valid,
  output logic [5:0] total_coin,
  output logic       coin_reject,
  output logic       busy
);

  localparam logic [5:0] P_TEA    = 6'(PRICE_TEA);
  localparam logic [5:0] P_COKE   = 6'(PRICE_COKE);
  localparam logic [5:0] P_COFFEE = 6'(PRICE_COFFEE);
  localparam logic [5:0] P_MILK   = 6'(PRICE_MILK);

  state_t     r_state;
  logic [5:0] r_total;
  logic [2:0] r_give;
  logic       r_give_valid;
  logic [5:0] r_refund_coin;
  logic       r_refund_valid;
  logic       r_coin_reject;
  logic       r_busy;

  state_t     w_state_nxt;
  logic [5:0] w_total_nxt;
  logic [2:0] w_give_nxt;
  logic       w_coin_acc;
  logic       w_coin_ok;
  logic [6:0] w_sum;
  logic [5:0] w_price;
  logic       w_price_vld;
  logic [5:0] w_change_coin;

  // Sum is one bit wider so a coin that would overflow the 6-bit credit is visible.
  assign w_sum     = {1'b0, r_total} + {1'b0, coin};
  assign w_coin_ok = ((coin == COIN_1) || (coin == COIN_5) || (coin == COIN_10)) &&
                     (w_sum <= 7'd63);

  always_comb begin
    w_price     = '0;
    w_price_vld = 1'b0;
    case (drink_choose)
      DRINK_TEA:    begin w_price = P_TEA;    w_price_vld = 1'b1; end
      DRINK_COKE:   begin w_price = P_COKE;   w_price_vld = 1'b1; end
      DRINK_COFFEE: begin w_price = P_COFFEE; w_price_vld = 1'b1; end
      DRINK_MILK:   begin w_price = P_MILK;   w_price_vld = 1'b1; end
      default:      begin w_price = '0;       w_price_vld = 1'b0; end
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_total_nxt = r_total;
    w_give_nxt  = r_give;
    w_coin_acc  = 1'b0;
    case (r_state)
      ST_IDLE, ST_ACCUM: begin
        if ((r_state == ST_ACCUM) && cancel) begin
          // Cancel outranks both coin and selection; any coin this cycle is refused.
          w_state_nxt = ST_CHANGE;
        end else if (coin_valid) begin
          // A coin cycle never evaluates the selection.
          if (w_coin_ok) begin
            w_total_nxt = w_sum[5:0];
            w_coin_acc  = 1'b1;
          end
          w_state_nxt = (w_total_nxt == '0) ? ST_IDLE : ST_ACCUM;
        end else if ((r_state == ST_ACCUM) && w_price_vld && (r_total >= w_price)) begin
          w_total_nxt = r_total - w_price;
          w_give_nxt  = drink_choose;
          w_state_nxt = ST_DISPENSE;
        end
      end
      ST_DISPENSE: begin
        if (disp_ready) begin
          w_state_nxt = (r_total != '0) ? ST_CHANGE : ST_IDLE;
        end
      end
      ST_CHANGE: begin
        if (refund_ready) begin
          w_total_nxt = r_total - r_refund_coin;
          w_state_nxt = (w_total_nxt == '0) ? ST_IDLE : ST_CHANGE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Change is computed from the next credit so the coin is registered with the
  // state entering/staying in CHANGE; with no handshake the credit is unchanged,
  // which keeps refund_coin stable while stalled.
  change_maker u_change_maker (
    .i_credit (w_total_nxt),
    .o_coin   (w_change_coin)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= ST_IDLE;
      r_total        <= '0;
      r_give         <= '0;
      r_give_valid   <= 1'b0;
      r_refund_coin  <= '0;
      r_refund_valid <= 1'b0;
      r_coin_reject  <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_total        <= w_total_nxt;
      r_give         <= (w_state_nxt == ST_DISPENSE) ? w_give_nxt : 3'b000;
      r_give_valid   <= (w_state_nxt == ST_DISPENSE);
      r_refund_coin  <= (w_state_nxt == ST_CHANGE) ? w_change_coin : 6'd0;
      r_refund_valid <= (w_state_nxt == ST_CHANGE);
      r_coin_reject  <= coin_valid && !w_coin_acc;
      r_busy         <= (w_state_nxt == ST_DISPENSE) || (w_state_nxt == ST_CHANGE);
    end
  end

  assign give         = r_give;
  assign give_valid   = r_give_valid;
  assign refund_coin  = r_refund_coin;
  assign refund_valid = r_refund_valid;
  assign total_coin   = r_total;
  assign coin_reject  = r_coin_reject;
  assign busy         = r_busy;

endmodule

// File: doc/vend_controller.md
VEND_CONTROLLER -- requirements
Module: vend_controller

Interface
REQ-001 Parameter PRICE_TEA, default 10, price of drink code 3'b001.
REQ-002 Parameter PRICE_COKE, default 15, price of drink code 3'b010.
REQ-003 Parameter PRICE_COFFEE, default 20, price of drink code 3'b011.
REQ-004 Parameter PRICE_MILK, default 25, price of drink code 3'b100.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 coin  input  6  inserted coin value; qualified by coin_valid.
REQ-008 coin_valid  input  1  one coin offered this cycle.
REQ-009 drink_choose  input  3  drink code (000 none, 001 tea, 010 coke, 011 coffee, 100 milk).
REQ-010 cancel  input  1  request refund of the full credit.
REQ-011 disp_ready  input  1  dispenser accepts the drink on give.
REQ-012 refund_ready  input  1  coin hopper accepts refund_coin.
REQ-013 give  output  3  drink code being dispensed; 000 when give_valid is low.
REQ-014 give_valid  output  1  dispense request.
REQ-015 refund_coin  output  6  change coin (10, 5 or 1); 0 when refund_valid is low.
REQ-016 refund_valid  output  1  change coin request.
REQ-017 total_coin  output  6  current credit register.
REQ-018 coin_reject  output  1  one-cycle pulse; the offered coin was refused.
REQ-019 busy  output  1  high in DISPENSE or CHANGE.

Function
REQ-020 The FSM SHALL have the states IDLE, ACCUM, DISPENSE and CHANGE; IDLE and ACCUM differ only in total_coin being 0 or nonzero.
REQ-021 In IDLE/ACCUM, a coin_valid with coin in {1,5,10} and total_coin+coin <= 63 SHALL add coin to total_coin at the next edge.
REQ-022 Any other coin value, an overflowing coin, or any coin offered in DISPENSE/CHANGE SHALL leave total_coin unchanged and pulse coin_reject in the next cycle.
REQ-023 In ACCUM, a drink_choose of 001..100 with coin_valid and cancel low, and total_coin >= price, SHALL subtract the price, latch the code and enter DISPENSE; give_valid SHALL rise in the following cycle.
REQ-024 Codes 101..111, code 000, or insufficient credit SHALL be ignored: no state change and no give_valid.
REQ-025 While coin_valid is high, drink_choose SHALL be ignored that cycle.
REQ-026 cancel in ACCUM SHALL take priority over coin and selection (the coin is rejected) and SHALL enter CHANGE with the full credit; cancel in IDLE, DISPENSE or CHANGE SHALL be ignored.
REQ-027 DISPENSE SHALL hold give and give_valid until disp_ready is sampled high, then go to CHANGE if total_coin > 0, else to IDLE.
REQ-028 CHANGE SHALL present the largest coin in {10,5,1} that is <= total_coin, with refund_valid held stable until refund_ready.
REQ-029 On each refund_ready handshake, total_coin SHALL decrease by refund_coin; when it reaches 0 the FSM SHALL enter IDLE in the same edge, and refund_valid SHALL drop.
REQ-030 All outputs SHALL be registered; none SHALL depend combinationally on inputs.

Reset
REQ-031 While reset is low, the FSM SHALL be IDLE and total_coin, give, give_valid, refund_coin, refund_valid, coin_reject and busy SHALL be 0, asynchronously.
REQ-032 Reset mid-DISPENSE or mid-CHANGE SHALL abandon the transaction and discard the credit; no partial refund SHALL follow.

Structure
REQ-033 Package vend_pkg SHALL hold the state enum, the drink-code constants, the coin denomination constants and the default prices.
REQ-034 Greedy coin selection SHALL be a sub-module change_maker (6-bit remaining credit in; 6-bit coin out).

Verification
REQ-035 Insert coins 5,5,1,1,10 (total 22), choose 010, disp_ready after 2 cycles -> give=010 held 2 cycles, total 7, refunds 5,1,1, then IDLE and total 0.
REQ-036 Total 10, choose 100 -> no give_valid, total stays 10, state ACCUM.
REQ-037 Total 16, cancel with a coin 5 offered in the same cycle -> coin_reject pulse, refunds 10,5,1, with refund_ready stalled 3 cycles on the first coin and refund_coin stable throughout.
REQ-038 Coin 7 -> reject; total 60 plus coin 5 -> reject, total stays 60; total 53 plus coin 10 -> accepted, total 63.
REQ-039 Total exactly 10, choose 001 -> give=001, then IDLE directly with no refund_valid.
REQ-040 reset low asserted asynchronously mid-CHANGE (between clock edges) -> all outputs 0 immediately; after release, IDLE with total 0 and no further refund.
